// File: rtl/mips_cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_cpu_pkg
// Description : Shared types and constants for the multicycle MIPS CPU memory
//               path: bus width defaults, full-word byte enable, the bridge
//               state encoding and a word-alignment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_cpu_pkg;

    localparam int unsigned CPU_ADDR_W  = 32;
    localparam int unsigned CPU_DATA_W  = 32;
    localparam logic [3:0]  BYTEEN_WORD = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } bridge_state_t;

    // Single-word accesses are only legal on 4-byte boundaries.
    function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb == 2'b00);
    endfunction

endpackage : mips_cpu_pkg
`default_nettype wire

// File: rtl/mips_cpu_bus_timer.sv
`default_nettype none
// ============================================================================
// Module      : mips_cpu_bus_timer
// Description : Saturating wait-cycle counter for one bus transaction.
//               o_expired is combinational: it is high in the cycle whose
//               count increment makes the total reach TIMEOUT, so the owner
//               can abort on that same edge. TIMEOUT = 0 disables expiry.
// Ports       : clk       - clock, rising edge
//               rst       - synchronous active-high reset
//               i_clr     - clear count to zero (transaction start)
//               i_en      - count this cycle (waitrequest seen high)
//               o_expired - this counted cycle reaches the TIMEOUT limit
// Revision    : 1.0 - initial release
// ============================================================================
module mips_cpu_bus_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int unsigned      CNT_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] C_MAX     = '1;
    localparam logic [CNT_W-1:0] C_LIMIT   = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam bit               C_ENABLED = (TIMEOUT != 0);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != C_MAX)) begin
            // Hold at all-ones rather than wrapping back to zero.
            r_count <= r_count + 1'b1;
        end
    end

    // r_count holds the wait cycles already seen; this cycle would be one more.
    assign o_expired = C_ENABLED && i_en && (r_count >= C_LIMIT);

endmodule : mips_cpu_bus_timer
`default_nettype wire

// File: rtl/mips_cpu_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : mips_cpu_mem_bridge
// Description : Converts the multicycle controller's single-word memread /
//               memwrite requests into Avalon-MM master transactions, returns
//               read data, stalls the sequencer until the bus completes, and
//               traps misaligned, conflicting and timed-out accesses.
// Ports       : clk, reset              - clock / sync active-high reset
//               mem_read, mem_write     - controller requests (held)
//               mem_addr, mem_wdata     - byte address / store data
//               mem_byteenable          - byte lanes
//               mem_rdata, rdata_valid  - registered read data / update pulse
//               stall                   - hold sequencer state
//               bus_error               - sticky fault flag
//               avm_*                   - Avalon-MM master interface
// Revision    : 1.0 - initial release
// ============================================================================
module mips_cpu_mem_bridge
    import mips_cpu_pkg::*;
#(
    parameter int unsigned ADDR_W  = CPU_ADDR_W,
    parameter int unsigned DATA_W  = CPU_DATA_W,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [3:0]        mem_byteenable,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              rdata_valid,
    output logic              stall,
    output logic              bus_error,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [DATA_W-1:0] avm_writedata,
    output logic [3:0]        avm_byteenable,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata
);

    bridge_state_t     r_state;
    bridge_state_t     w_state_next;

    logic [ADDR_W-1:0] r_avm_address,    w_avm_address_n;
    logic              r_avm_read,       w_avm_read_n;
    logic              r_avm_write,      w_avm_write_n;
    logic [DATA_W-1:0] r_avm_writedata,  w_avm_writedata_n;
    logic [3:0]        r_avm_byteenable, w_avm_byteenable_n;
    logic [DATA_W-1:0] r_mem_rdata,      w_mem_rdata_n;
    logic              r_rdata_valid,    w_rdata_valid_n;
    logic              r_bus_error,      w_bus_error_n;

    logic              w_stall;
    logic              w_tmr_clr;
    logic              w_tmr_en;
    logic              w_tmr_expired;

    mips_cpu_bus_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_bus_timer (
        .clk       (clk),
        .rst       (reset),
        .i_clr     (w_tmr_clr),
        .i_en      (w_tmr_en),
        .o_expired (w_tmr_expired)
    );

    // ------------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= ST_IDLE;
            r_avm_address    <= '0;
            r_avm_read       <= 1'b0;
            r_avm_write      <= 1'b0;
            r_avm_writedata  <= '0;
            r_avm_byteenable <= 4'h0;
            r_mem_rdata      <= '0;
            r_rdata_valid    <= 1'b0;
            r_bus_error      <= 1'b0;
        end else begin
            r_state          <= w_state_next;
            r_avm_address    <= w_avm_address_n;
            r_avm_read       <= w_avm_read_n;
            r_avm_write      <= w_avm_write_n;
            r_avm_writedata  <= w_avm_writedata_n;
            r_avm_byteenable <= w_avm_byteenable_n;
            r_mem_rdata      <= w_mem_rdata_n;
            r_rdata_valid    <= w_rdata_valid_n;
            r_bus_error      <= w_bus_error_n;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state, next-output and stall logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next       = r_state;
        w_avm_address_n    = r_avm_address;
        w_avm_read_n       = r_avm_read;
        w_avm_write_n      = r_avm_write;
        w_avm_writedata_n  = r_avm_writedata;
        w_avm_byteenable_n = r_avm_byteenable;
        w_mem_rdata_n      = r_mem_rdata;
        w_rdata_valid_n    = 1'b0;
        w_bus_error_n      = r_bus_error;
        w_stall            = 1'b0;
        w_tmr_clr          = 1'b0;
        w_tmr_en           = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_stall = mem_read | mem_write;
                if (mem_read && mem_write) begin
                    w_state_next  = ST_ERROR;
                    w_bus_error_n = 1'b1;
                end else if (mem_read || mem_write) begin
                    if (!is_word_aligned(mem_addr[1:0])) begin
                        // Trap before anything reaches the bus.
                        w_state_next  = ST_ERROR;
                        w_bus_error_n = 1'b1;
                    end else begin
                        w_avm_address_n    = {mem_addr[ADDR_W-1:2], 2'b00};
                        w_avm_byteenable_n = mem_byteenable;
                        w_tmr_clr          = 1'b1;
                        if (mem_read) begin
                            w_avm_read_n = 1'b1;
                            w_state_next = ST_READ;
                        end else begin
                            w_avm_write_n     = 1'b1;
                            w_avm_writedata_n = mem_wdata;
                            w_state_next      = ST_WRITE;
                        end
                    end
                end
            end

            ST_READ, ST_WRITE: begin
                w_stall  = 1'b1;
                w_tmr_en = avm_waitrequest;
                if (!avm_waitrequest) begin
                    // Slave accepts on this edge; completion wins over timeout.
                    w_avm_read_n  = 1'b0;
                    w_avm_write_n = 1'b0;
                    w_state_next  = ST_DONE;
                    if (r_state == ST_READ) begin
                        w_mem_rdata_n   = avm_readdata;
                        w_rdata_valid_n = 1'b1;
                    end
                end else if (w_tmr_expired) begin
                    w_avm_read_n  = 1'b0;
                    w_avm_write_n = 1'b0;
                    w_state_next  = ST_ERROR;
                    w_bus_error_n = 1'b1;
                end
            end

            ST_DONE: begin
                // One stall-free cycle lets the sequencer advance; any request
                // still presented here is the old one and is not re-issued.
                w_stall      = 1'b0;
                w_state_next = ST_IDLE;
            end

            ST_ERROR: begin
                // Terminal until reset: CPU stays frozen, bus stays quiet.
                w_stall = 1'b1;
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign mem_rdata      = r_mem_rdata;
    assign rdata_valid    = r_rdata_valid;
    assign stall          = w_stall;
    assign bus_error      = r_bus_error;
    assign avm_address    = r_avm_address;
    assign avm_read       = r_avm_read;
    assign avm_write      = r_avm_write;
    assign avm_writedata  = r_avm_writedata;
    assign avm_byteenable = r_avm_byteenable;

endmodule : mips_cpu_mem_bridge
`default_nettype wire

// File: tb/tb_mips_cpu_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_cpu_mem_bridge
// Description : Self-checking bench for mips_cpu_mem_bridge. A transaction
//               level model predicts, per request, whether it traps, how many
//               cycles the strobe stays high, and the resulting read data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_cpu_mem_bridge;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_rdata;
    logic        rdata_valid, stall, bus_error;
    logic [31:0] avm_address, avm_writedata, avm_readdata;
    logic        avm_read, avm_write, avm_waitrequest;
    logic [3:0]  avm_byteenable;

    // Second instance with the timeout disabled.
    logic        z_reset, z_read, z_write, z_wait;
    logic [31:0] z_addr, z_wdata, z_readdata;
    logic [31:0] z_mem_rdata, z_avm_address, z_avm_writedata;
    logic        z_rdata_valid, z_stall, z_bus_error, z_avm_read, z_avm_write;
    logic [3:0]  z_avm_byteenable;

    always #5 clk = ~clk;

    mips_cpu_mem_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) u_dut (
        .clk(clk), .reset(reset),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_byteenable(mem_byteenable),
        .mem_rdata(mem_rdata), .rdata_valid(rdata_valid), .stall(stall),
        .bus_error(bus_error), .avm_address(avm_address), .avm_read(avm_read),
        .avm_write(avm_write), .avm_writedata(avm_writedata),
        .avm_byteenable(avm_byteenable), .avm_waitrequest(avm_waitrequest),
        .avm_readdata(avm_readdata)
    );

    mips_cpu_mem_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(0)) u_dut_nto (
        .clk(clk), .reset(z_reset),
        .mem_read(z_read), .mem_write(z_write), .mem_addr(z_addr),
        .mem_wdata(z_wdata), .mem_byteenable(4'hF),
        .mem_rdata(z_mem_rdata), .rdata_valid(z_rdata_valid), .stall(z_stall),
        .bus_error(z_bus_error), .avm_address(z_avm_address), .avm_read(z_avm_read),
        .avm_write(z_avm_write), .avm_writedata(z_avm_writedata),
        .avm_byteenable(z_avm_byteenable), .avm_waitrequest(z_wait),
        .avm_readdata(z_readdata)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          write_accepts = 0;
    logic [31:0] model_rdata = '0;

    // Count accepted write beats to prove each store hits the bus exactly once.
    always @(posedge clk) begin
        if (reset) write_accepts <= 0;
        else if (avm_write && !avm_waitrequest) write_accepts <= write_accepts + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state();
        check("rst_avm_read",  avm_read,    0);
        check("rst_avm_write", avm_write,   0);
        check("rst_avm_addr",  avm_address, 0);
        check("rst_avm_be",    avm_byteenable, 0);
        check("rst_stall",     stall,       0);
        check("rst_bus_error", bus_error,   0);
        check("rst_rdata",     mem_rdata,   0);
        check("rst_valid",     rdata_valid, 0);
    endtask

    // Called at a negedge; leaves the DUT in IDLE at a later negedge.
    task automatic do_reset();
        reset = 1'b1;
        mem_read = 1'b0; mem_write = 1'b0;
        avm_waitrequest = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_rdata = '0;
        check_reset_state();
    endtask

    // One controller request. Called at a negedge with the DUT idle.
    task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] be,
                           input int waits, input logic [31:0] rdv);
        bit err, tmo;
        int n_strobe, acc0;
        err      = (rd && wr) || (addr[1:0] != 2'b00);
        tmo      = !err && (waits >= int'(TMO));
        n_strobe = err ? 0 : (tmo ? int'(TMO) : waits + 1);
        acc0     = write_accepts;

        mem_read = rd; mem_write = wr; mem_addr = addr; mem_wdata = wd;
        mem_byteenable = be; avm_waitrequest = 1'b1; avm_readdata = $urandom;
        #1 check("idle_req_stall", stall, 1);

        for (int i = 0; i < n_strobe; i++) begin
            @(negedge clk);
            check("strobe_read",  avm_read,  rd);
            check("strobe_write", avm_write, wr);
            check("strobe_addr",  avm_address, addr);
            check("strobe_be",    avm_byteenable, be);
            if (wr) check("strobe_wdata", avm_writedata, wd);
            check("busy_stall",   stall, 1);
            check("busy_valid",   rdata_valid, 0);
            avm_waitrequest = (i < waits);
            avm_readdata    = (i < waits) ? $urandom : rdv;
        end

        @(negedge clk);
        if (err || tmo) begin
            check("err_read",      avm_read,  0);
            check("err_write",     avm_write, 0);
            check("err_bus_error", bus_error, 1);
            check("err_stall",     stall,     1);
            check("err_valid",     rdata_valid, 0);
            check("err_rdata",     mem_rdata, model_rdata);
            @(negedge clk);
            check("err_quiet",     avm_read | avm_write, 0);
            check("err_accepts",   write_accepts, acc0);
            do_reset();
        end else begin
            if (rd) model_rdata = rdv;
            check("done_stall",  stall, 0);
            check("done_valid",  rdata_valid, rd);
            check("done_strobe", avm_read | avm_write, 0);
            check("done_rdata",  mem_rdata, model_rdata);
            check("done_error",  bus_error, 0);
            // Request still held through DONE: must not start a new cycle.
            @(negedge clk);
            check("post_no_reissue", avm_read | avm_write, 0);
            check("post_valid",      rdata_valid, 0);
            check("post_accepts",    write_accepts, acc0 + (wr ? 1 : 0));
            mem_read = 1'b0; mem_write = 1'b0;
            #1 check("post_stall", stall, 0);
        end
    endtask

    initial begin
        logic [31:0] ra, rw, rv;
        int          kind, w;
        bit          trd, twr;

        reset = 1'b1; mem_read = 0; mem_write = 0; mem_addr = '0; mem_wdata = '0;
        mem_byteenable = 4'hF; avm_waitrequest = 1'b0; avm_readdata = '0;
        z_reset = 1'b1; z_read = 0; z_write = 0; z_wait = 1'b1;
        z_addr = '0; z_wdata = '0; z_readdata = '0;
        repeat (2) @(negedge clk);
        z_reset = 1'b0;
        do_reset();

        // Directed cases.
        run_txn(1, 0, 32'h1000_0010, 32'h0, 4'hF, 0, 32'hDEAD_BEEF);
        run_txn(0, 1, 32'h0000_0020, 32'h1234_5678, 4'hF, 3, 32'h0);
        run_txn(1, 0, 32'h0000_0000, 32'h0, 4'hF, 1, 32'h0BAD_F00D);
        run_txn(1, 0, 32'h0000_0100, 32'h0, 4'hF, 0, 32'h8C09_0004);
        run_txn(1, 0, 32'h0000_0022, 32'h0, 4'hF, 0, 32'h5555_5555);
        run_txn(1, 0, 32'h0000_0040, 32'h0, 4'hF, 3, 32'hA5A5_0003);
        run_txn(1, 0, 32'h0000_0044, 32'h0, 4'hF, TMO, 32'h0);
        run_txn(1, 1, 32'h0000_0048, 32'h1, 4'hF, 0, 32'h0);

        // Reset while a read is waiting on the slave.
        run_txn(1, 0, 32'h0000_0080, 32'h0, 4'hF, 0, 32'h7777_0080);
        mem_read = 1'b1; mem_addr = 32'h0000_0090; avm_waitrequest = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("midread_strobe", avm_read, 1);
        do_reset();

        // Randomised requests.
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 15);
            ra   = $urandom;
            rw   = $urandom;
            rv   = $urandom;
            w    = ($urandom_range(0, 7) == 0) ? $urandom_range(TMO, TMO + 2) : $urandom_range(0, 3);
            trd  = (kind < 8) || (kind == 15);
            twr  = (kind >= 8);
            if (kind != 14) ra[1:0] = 2'b00;
            run_txn(trd, twr, ra, rw, 4'($urandom_range(1, 15)), w, rv);
        end

        // TIMEOUT = 0: a long stall must never trap.
        z_read = 1'b1; z_addr = 32'h0000_0200; z_wait = 1'b1;
        repeat (300) @(negedge clk);
        check("nto_strobe_held", z_avm_read,  1);
        check("nto_no_error",    z_bus_error, 0);
        check("nto_stall",       z_stall,     1);
        z_wait = 1'b0; z_readdata = 32'hCAFE_F00D;
        @(negedge clk);
        check("nto_valid", z_rdata_valid, 1);
        check("nto_rdata", z_mem_rdata,   32'hCAFE_F00D);
        check("nto_done_stall", z_stall,  0);
        z_read = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mips_cpu_mem_bridge
`default_nettype wire
